// File: rtl/vedm_telemetry_pkg.sv
// Shared constants, TX state encoding and frame checksum for the voltage telemetry path.
package vedm_telemetry_pkg;

  localparam logic [7:0] FRAME_SYNC  = 8'hA5;
  localparam int         FRAME_BYTES = 5;

  typedef enum logic [2:0] {
    TX_IDLE,
    TX_START,
    TX_DATA,
    TX_STOP,
    TX_NEXT
  } tx_state_e;

  function automatic logic [7:0] frame_chk(input logic [7:0] mn,
                                           input logic [7:0] mx,
                                           input logic [7:0] av);
    return FRAME_SYNC ^ mn ^ mx ^ av;
  endfunction

endpackage

// File: rtl/uart_tx_byte.sv
// 8N1 byte serialiser: start pulse loads a byte, done pulses in the last stop-bit cycle.
module uart_tx_byte
  import vedm_telemetry_pkg::*;
#(
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] data,
  output logic       tx,
  output logic       done
);

  localparam int unsigned CW = $clog2(CLKS_PER_BIT);
  localparam logic [CW-1:0] CNT_LAST = CW'(CLKS_PER_BIT - 1);

  tx_state_e     state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q;
  logic          cnt_last;

  assign cnt_last = (cnt_q == CNT_LAST);

  // NOTE: every variable gets a default before the case, so no path can infer a latch.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    done    = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (start) begin
          state_d = TX_START;
          cnt_d   = '0;
          sh_d    = data;
        end
      end
      TX_START: begin
        if (cnt_last) begin
          state_d = TX_DATA;
          cnt_d   = '0;
          bit_d   = '0;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_DATA: begin
        if (cnt_last) begin
          cnt_d = '0;
          sh_d  = sh_q >> 1;
          if (bit_q == 3'd7) state_d = TX_STOP;
          else               bit_d   = bit_q + 3'd1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      TX_STOP: begin
        if (cnt_last) begin
          state_d = TX_IDLE;
          cnt_d   = '0;
          done    = 1'b1;
        end else begin
          cnt_d = cnt_q + CW'(1);
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments only.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q <= TX_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      // Registered pin: the level follows the state being entered on this edge.
      tx_q    <= (state_d == TX_START) ? 1'b0 :
                 (state_d == TX_DATA)  ? sh_d[0] : 1'b1;
    end
  end

  assign tx = tx_q;

endmodule

// File: rtl/voltage_frame_tx.sv
// Window min/max/avg reducer with a one-entry snapshot buffer feeding a 5-byte UART frame sequencer.
module voltage_frame_tx
  import vedm_telemetry_pkg::*;
#(
  parameter int unsigned WIN_LOG2     = 4,
  parameter int unsigned CLKS_PER_BIT = 104
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [7:0] sample,
  input  logic       sample_valid,
  input  logic       clear_overrun,
  output logic       tx,
  output logic       busy,
  output logic       frame_sent,
  output logic       overrun
);

  localparam int unsigned SW = 8 + WIN_LOG2;

  // Window accumulator
  logic [7:0]          acc_min, acc_max;
  logic [SW-1:0]       acc_sum;
  logic [WIN_LOG2-1:0] acc_cnt;
  logic [7:0]          min_nx, max_nx, avg_nx;
  logic [SW-1:0]       sum_nx;
  logic                win_done;

  assign min_nx   = (sample < acc_min) ? sample : acc_min;
  assign max_nx   = (sample > acc_max) ? sample : acc_max;
  assign sum_nx   = acc_sum + SW'(sample);
  assign avg_nx   = sum_nx[WIN_LOG2 +: 8];
  assign win_done = sample_valid && (acc_cnt == '1);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      acc_min <= 8'hFF;
      acc_max <= 8'h00;
      acc_sum <= '0;
      acc_cnt <= '0;
    end else if (sample_valid) begin
      acc_cnt <= acc_cnt + WIN_LOG2'(1);
      if (win_done) begin
        acc_min <= 8'hFF;
        acc_max <= 8'h00;
        acc_sum <= '0;
      end else begin
        acc_min <= min_nx;
        acc_max <= max_nx;
        acc_sum <= sum_nx;
      end
    end
  end

  // Snapshot buffer, frame shift register and byte sequencer
  tx_state_e   state_q, state_d;
  logic        buf_full;
  logic [7:0]  buf_min, buf_max, buf_avg;
  logic [31:0] frame_sr;
  logic [2:0]  byte_idx;
  logic        load_frame, shift_byte;
  logic        byte_start, byte_done;
  logic [7:0]  byte_data;
  logic        drop;

  assign drop = win_done && buf_full;

  // The sequencer only uses IDLE, START (byte owned by the serialiser) and NEXT.
  always_comb begin
    state_d    = state_q;
    byte_start = 1'b0;
    byte_data  = FRAME_SYNC;
    load_frame = 1'b0;
    shift_byte = 1'b0;
    frame_sent = 1'b0;
    case (state_q)
      TX_IDLE: begin
        if (buf_full) begin
          byte_start = 1'b1;
          load_frame = 1'b1;
          state_d    = TX_START;
        end
      end
      TX_START: begin
        if (byte_done) state_d = TX_NEXT;
      end
      TX_NEXT: begin
        if (byte_idx < 3'(FRAME_BYTES - 1)) begin
          byte_start = 1'b1;
          byte_data  = frame_sr[31:24];
          shift_byte = 1'b1;
          state_d    = TX_START;
        end else begin
          frame_sent = 1'b1;
          state_d    = TX_IDLE;
        end
      end
      default: state_d = TX_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q  <= TX_IDLE;
      buf_full <= 1'b0;
      // NOTE: buffer and frame data are reset too; it is only a handful of flops.
      buf_min  <= '0;
      buf_max  <= '0;
      buf_avg  <= '0;
      frame_sr <= '0;
      byte_idx <= '0;
      overrun  <= 1'b0;
    end else begin
      state_q <= state_d;

      if (win_done && !buf_full) begin
        buf_full <= 1'b1;
        buf_min  <= min_nx;
        buf_max  <= max_nx;
        buf_avg  <= avg_nx;
      end else if (load_frame) begin
        buf_full <= 1'b0;
      end

      if (load_frame) begin
        frame_sr <= {buf_min, buf_max, buf_avg, frame_chk(buf_min, buf_max, buf_avg)};
        byte_idx <= '0;
      end else if (shift_byte) begin
        frame_sr <= {frame_sr[23:0], 8'h00};
        byte_idx <= byte_idx + 3'd1;
      end

      // A drop in the same cycle as a clear leaves the flag set.
      if (drop)               overrun <= 1'b1;
      else if (clear_overrun) overrun <= 1'b0;
    end
  end

  assign busy = (state_q != TX_IDLE);

  uart_tx_byte #(
    .CLKS_PER_BIT(CLKS_PER_BIT)
  ) u_uart_tx_byte (
    .clk  (clk),
    .rst  (rst),
    .start(byte_start),
    .data (byte_data),
    .tx   (tx),
    .done (byte_done)
  );

endmodule
